// File: rtl/card_cursor_ctrl.sv
// card_cursor_ctrl
// Turns five raw push-buttons into a cursor on the 4x4 card grid and offers
// the selected cell to the game logic through a valid/ready handshake.
// Cursor moves are held in a one-deep pending latch and committed only at the
// start of vertical blanking, so a drawn frame never shows a partial change.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst        synchronous active-high reset
//   btn_up/btn_down/btn_left/btn_right/btn_sel
//              raw asynchronous buttons, active-high
//   VCount     current line from the VGA timing generator
//   pos        committed cursor cell, row*4+col (row = pos[3:2], col = pos[1:0])
//   enable     high while the cursor is live (no selection outstanding)
//   sel_pos    offered cell
//   sel_valid  offer valid
//   sel_ready  consumer accepts the offer
module card_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int VBLANK_LINE     = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [9:0] VCount,
  output logic [3:0] pos,
  output logic       enable,
  output logic [3:0] sel_pos,
  output logic       sel_valid,
  input  logic       sel_ready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OFFER   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]       VB_LINE = 10'(VBLANK_LINE);

  // Button lanes: 0 up, 1 down, 2 left, 3 right, 4 select
  localparam int unsigned NBTN = 5;

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  s;
  logic [NBTN-1:0]  stable;
  logic [NBTN-1:0]  press;
  logic [CNT_W-1:0] cnt [NBTN];

  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // Synchronizer + debouncer. The press pulse is registered on the same edge
  // that stable flips to 1, so it is high for exactly the first stable cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      s      <= '0;
      stable <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (s[i] == stable[i]) begin
          cnt[i]   <= '0;
          press[i] <= 1'b0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
          press[i]  <= s[i];
        end else begin
          cnt[i]   <= cnt[i] + 1'b1;
          press[i] <= 1'b0;
        end
      end
    end
  end

  // Target cell for a move press, always relative to the committed pos.
  logic [1:0] row, col;
  logic [1:0] row_dec, row_inc, col_dec, col_inc;
  logic       mv_hit;
  logic [3:0] mv_cell;

  assign row     = pos[3:2];
  assign col     = pos[1:0];
  assign row_dec = row - 2'd1;
  assign row_inc = row + 2'd1;
  assign col_dec = col - 2'd1;
  assign col_inc = col + 2'd1;

  always_comb begin
    mv_hit  = 1'b1;
    mv_cell = pos;
    if (press[0])      mv_cell = {row_dec, col};
    else if (press[1]) mv_cell = {row_inc, col};
    else if (press[2]) mv_cell = {row, col_dec};
    else if (press[3]) mv_cell = {row, col_inc};
    else               mv_hit  = 1'b0;
  end

  logic [9:0] vprev;
  logic       vb_start;

  assign vb_start = (VCount == VB_LINE) && (vprev != VB_LINE);

  logic [1:0] state, state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (press[4])             state_nx = OFFER;
      OFFER:   if (sel_ready)            state_nx = RELEASE;
      RELEASE: if (!stable[4])           state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  logic [3:0] pending;
  logic       pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vprev      <= '0;
      pos        <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      sel_pos    <= '0;
      sel_valid  <= 1'b0;
      enable     <= 1'b1;
    end else begin
      vprev     <= VCount;
      state     <= state_nx;
      // Outputs are registered from the next state so they line up with it.
      sel_valid <= (state_nx == OFFER);
      enable    <= (state_nx == IDLE);

      if (state == IDLE && press[4]) begin
        // A selection discards any queued move, including one due this cycle.
        sel_pos    <= pos;
        pend_valid <= 1'b0;
      end else begin
        if (vb_start && pend_valid) begin
          pos        <= pending;
          pend_valid <= 1'b0;
        end
        // Placed after the commit so a same-cycle press re-arms the latch
        // with a cell computed from the old pos, to land next frame.
        if (state == IDLE && mv_hit) begin
          pending    <= mv_cell;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_card_cursor_ctrl.sv
// tb_card_cursor_ctrl
// Table-driven bench for card_cursor_ctrl with DEBOUNCE_CYCLES=4.
// Each record drives inputs at a falling edge, lets `hold` rising edges pass,
// then compares pos/enable/sel_valid/sel_pos against hand-computed values.
module tb_card_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [9:0] VCount;
  logic [3:0] pos;
  logic       enable;
  logic [3:0] sel_pos;
  logic       sel_valid;
  logic       sel_ready;

  always #5 clk = ~clk;

  card_cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .VBLANK_LINE(480)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_sel(btn_sel),
    .VCount(VCount),
    .pos(pos),
    .enable(enable),
    .sel_pos(sel_pos),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready)
  );

  // Button bit order: {up, down, left, right, sel}
  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] U = 5'b10000;
  localparam logic [4:0] D = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] R = 5'b00010;
  localparam logic [4:0] S = 5'b00001;

  typedef struct {
    logic        rst;
    logic [4:0]  btn;
    logic [9:0]  vc;
    logic        rdy;
    int unsigned hold;
    logic [3:0]  ep;
    logic        een;
    logic        esv;
    logic [3:0]  esp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  task automatic r(input logic rs, input logic [4:0] b, input logic [9:0] vc,
                   input logic rdy, input int unsigned hold, input logic [3:0] ep,
                   input logic een, input logic esv, input logic [3:0] esp);
    tbl.push_back('{rs, b, vc, rdy, hold, ep, een, esv, esp});
  endtask

  // Press and release a move button while idle; pos stays put until blanking.
  task automatic tap(input logic [4:0] b, input logic [3:0] p, input logic [3:0] sp);
    r(1'b0, b, 10'd0, 1'b0, 8, p, 1'b1, 1'b0, sp);
    r(1'b0, N, 10'd0, 1'b0, 8, p, 1'b1, 1'b0, sp);
  endtask

  // One blanking start, expecting pos to be p right after it.
  task automatic vb(input logic [3:0] p, input logic [3:0] sp);
    r(1'b0, N, 10'd480, 1'b0, 1, p, 1'b1, 1'b0, sp);
    r(1'b0, N, 10'd0,   1'b0, 1, p, 1'b1, 1'b0, sp);
  endtask

  task automatic drive(input logic rs, input logic [4:0] b, input logic [9:0] vc,
                       input logic rdy);
    rst       = rs;
    btn_up    = b[4];
    btn_down  = b[3];
    btn_left  = b[2];
    btn_right = b[1];
    btn_sel   = b[0];
    VCount    = vc;
    sel_ready = rdy;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, got, exp);
  endtask

  task automatic chk_all(input int idx, input logic [3:0] ep, input logic een,
                         input logic esv, input logic [3:0] esp);
    chk("pos",       idx, pos,               ep);
    chk("enable",    idx, {3'b000, enable},    {3'b000, een});
    chk("sel_valid", idx, {3'b000, sel_valid}, {3'b000, esv});
    chk("sel_pos",   idx, sel_pos,           esp);
  endtask

  initial begin
    drive(1'b1, N, 10'd0, 1'b0);

    // Reset, then a 3-cycle bounce that must not register
    r(1'b1, N, 10'd0, 1'b0, 2, 4'd0, 1'b1, 1'b0, 4'd0);
    r(1'b0, R, 10'd0, 1'b0, 3, 4'd0, 1'b1, 1'b0, 4'd0);
    r(1'b0, N, 10'd0, 1'b0, 8, 4'd0, 1'b1, 1'b0, 4'd0);
    vb(4'd0, 4'd0);
    // Debounced right, committed exactly on the vb_start edge
    r(1'b0, R, 10'd0,   1'b0, 10, 4'd0, 1'b1, 1'b0, 4'd0);
    r(1'b0, N, 10'd479, 1'b0, 8,  4'd0, 1'b1, 1'b0, 4'd0);
    r(1'b0, N, 10'd480, 1'b0, 1,  4'd1, 1'b1, 1'b0, 4'd0);
    r(1'b0, N, 10'd480, 1'b0, 3,  4'd1, 1'b1, 1'b0, 4'd0);
    r(1'b0, N, 10'd0,   1'b0, 1,  4'd1, 1'b1, 1'b0, 4'd0);

    // Wrap
    r(1'b1, N, 10'd0, 1'b0, 2, 4'd0, 1'b1, 1'b0, 4'd0);
    tap(L, 4'd0, 4'd0);  vb(4'd3, 4'd0);
    tap(U, 4'd3, 4'd0);  vb(4'd15, 4'd0);
    tap(D, 4'd15, 4'd0); vb(4'd3, 4'd0);

    // Last press wins; same-cycle priority up over right
    r(1'b1, N, 10'd0, 1'b0, 2, 4'd0, 1'b1, 1'b0, 4'd0);
    tap(R, 4'd0, 4'd0);  tap(R, 4'd0, 4'd0); vb(4'd1, 4'd0);
    tap(D, 4'd1, 4'd0);  vb(4'd5, 4'd0);
    tap(U | R, 4'd5, 4'd0); vb(4'd1, 4'd0);

    // Selection handshake at pos 6
    tap(D, 4'd1, 4'd0);  vb(4'd5, 4'd0);
    tap(R, 4'd5, 4'd0);  vb(4'd6, 4'd0);
    r(1'b0, S,     10'd0,   1'b0, 8,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S,     10'd0,   1'b0, 12, 4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S | R, 10'd0,   1'b0, 8,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S,     10'd0,   1'b0, 8,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S,     10'd480, 1'b0, 1,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S,     10'd0,   1'b0, 1,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b0, S,     10'd0,   1'b1, 1,  4'd6, 1'b0, 1'b0, 4'd6);
    // Held select: stays in RELEASE, no second offer
    r(1'b0, S,     10'd0,   1'b0, 10, 4'd6, 1'b0, 1'b0, 4'd6);
    r(1'b0, N,     10'd0,   1'b0, 6,  4'd6, 1'b0, 1'b0, 4'd6);
    r(1'b0, N,     10'd0,   1'b0, 1,  4'd6, 1'b1, 1'b0, 4'd6);
    // Press again, then reset mid-offer
    r(1'b0, S,     10'd0,   1'b0, 8,  4'd6, 1'b0, 1'b1, 4'd6);
    r(1'b1, N,     10'd0,   1'b0, 1,  4'd0, 1'b1, 1'b0, 4'd0);
    r(1'b0, N,     10'd0,   1'b0, 8,  4'd0, 1'b1, 1'b0, 4'd0);
    vb(4'd0, 4'd0);
    // Pending move does not survive reset
    tap(R, 4'd0, 4'd0);
    r(1'b1, N, 10'd0, 1'b0, 1, 4'd0, 1'b1, 1'b0, 4'd0);
    vb(4'd0, 4'd0);

    // Minimum OFFER dwell with sel_ready already high
    tap(L, 4'd0, 4'd0);  vb(4'd3, 4'd0);
    r(1'b0, S, 10'd0, 1'b1, 7, 4'd3, 1'b0, 1'b1, 4'd3);
    r(1'b0, S, 10'd0, 1'b1, 1, 4'd3, 1'b0, 1'b0, 4'd3);
    r(1'b0, N, 10'd0, 1'b0, 7, 4'd3, 1'b1, 1'b0, 4'd3);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].btn, tbl[i].vc, tbl[i].rdy);
      repeat (tbl[i].hold) @(negedge clk);
      chk_all(i, tbl[i].ep, tbl[i].een, tbl[i].esv, tbl[i].esp);
    end

    // Hand sequence: press pulse coincides with vb_start. The older pending
    // right (3 -> 0) commits; the down press uses old pos 3 and lands at 7.
    drive(1'b0, R, 10'd0, 1'b0); repeat (8) @(negedge clk);
    drive(1'b0, N, 10'd0, 1'b0); repeat (8) @(negedge clk);
    chk("hs_pend", 1000, pos, 4'd3);
    drive(1'b0, D, 10'd0, 1'b0); repeat (6) @(negedge clk);
    drive(1'b0, D, 10'd480, 1'b0); @(negedge clk);
    chk("hs_commit", 1001, pos, 4'd0);
    drive(1'b0, N, 10'd0, 1'b0); repeat (8) @(negedge clk);
    chk("hs_wait", 1002, pos, 4'd0);
    drive(1'b0, N, 10'd480, 1'b0); @(negedge clk);
    chk("hs_next", 1003, pos, 4'd7);
    drive(1'b0, N, 10'd0, 1'b0); @(negedge clk);
    chk("hs_en", 1004, {3'b000, enable}, 4'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/card_cursor_ctrl.md
# card_cursor_ctrl

Produces the `pos` index and the `enable` qualifier that the card renderer consumes. It turns five raw push-buttons into a cursor on the 4×4 card grid and offers the chosen cell to the game logic through a valid/ready handshake. Cursor moves are committed only at the start of vertical blanking, so a drawn frame never shows a cursor change part-way through. The block sits between the board buttons and the game FSM, alongside the VGA timing generator.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive clocks a synchronized button must disagree with its stable state before the stable state flips (10 ms at 25 MHz).
- `CNT_W`, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `VBLANK_LINE`, 480: first VCount value of vertical blanking.
- `clk` in 1: pixel clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel` in 1 each: raw asynchronous buttons, active-high.
- `VCount` in 10: current line from the VGA timing generator.
- `pos` out 4: cursor cell as row*4+col; row is pos[3:2], col is pos[1:0].
- `enable` out 1: high while the cursor is live, low while a selection is outstanding.
- `sel_pos` out 4: offered cell.
- `sel_valid` out 1: offer valid.
- `sel_ready` in 1: consumer accepts the offer.

## Operation
- **Per button**
  - Two-flop synchronizer produces `s`.
  - CNT_W counter counts every cycle that `s` differs from `stable`.
  - The counter clears on any cycle where `s` equals `stable`.
  - When the counter reaches DEBOUNCE_CYCLES−1 and `s` still differs, `stable` takes `s` and the counter clears.
  - A registered one-cycle `press` pulse fires on each 0→1 transition of `stable`. Release produces no pulse.
- **Move latch**
  - On a move press, a 4-bit `pending` cell is computed from the currently committed `pos` and replaces any earlier pending move. The last move pressed before blanking wins; moves do not accumulate.
  - Same-cycle priority: up > down > left > right. Lower-priority presses that cycle are dropped.
  - Moves wrap within their row or column: left from col 0 goes to col 3, and up from row 0 goes to row 3, with the other coordinate unchanged.
- **Commit**
  - `vb_start` is high when VCount == VBLANK_LINE and the registered previous VCount != VBLANK_LINE.
  - On `vb_start` with a move pending, `pos` takes `pending` and the pending flag clears.
  - If a press and `vb_start` occur in the same cycle, the press is computed from the old `pos` and waits for the next frame.
- **Selection FSM** (IDLE, OFFER, RELEASE)
  - **IDLE**: `enable`=1. A `btn_sel` press captures `sel_pos` from the current `pos`, clears any pending move, and goes to OFFER.
  - **OFFER**: `sel_valid`=1 and `enable`=0. `sel_pos` holds stable. Move presses and select presses are ignored. When `sel_valid`&&`sel_ready`, go to RELEASE.
  - **RELEASE**: `sel_valid`=0 and `enable`=0. Move presses are ignored. When `btn_sel` stable is 0, go to IDLE.
  - `sel_ready` outside OFFER has no effect.
- **Reset**
  - Clears synchronizers, stable states, counters, press pulses, pending flag, and FSM (to IDLE).
  - `pos`=0, `sel_pos`=0, `sel_valid`=0, `enable`=1 on the first cycle after reset.
  - A reset during debounce or during OFFER discards the press or offer without a handshake.

## Timing
- Raw button rises at edge 0 and then stays high:
  - `s` is high after edge 2.
  - `stable` rises after edge 2+DEBOUNCE_CYCLES.
  - `press` is high during the following cycle, ending at edge 3+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles of `s` produces no pulse.
- `pos` changes only on the clock edge where `vb_start` is high: one change per frame at most.
- The FSM leaves IDLE on the edge after the select press pulse. `sel_valid` and `enable`=0 are visible in the next cycle.
- The OFFER→RELEASE transition occurs on the handshake edge, and `sel_valid` is low in the next cycle.
- The minimum OFFER dwell is 1 cycle, which happens when `sel_ready` is already high.
- All outputs are registered; there are no combinational paths from any input to any output.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, VBLANK_LINE=480.

- **Reset, bounce, debounced press**: reset, then pulse `btn_right` high for 3 cycles. Expect no press and `pos`=0. Then hold `btn_right` 10 cycles and sweep VCount through 480. Expect `pos`=1, changing exactly on the `vb_start` edge, and `enable`=1 throughout.
- **Wrap**: from `pos`=0, press left then commit at blanking, expecting `pos`=3. Then press up and commit, expecting `pos`=15. Then press down and commit, expecting `pos`=3.
- **Last-wins and priority**: two right presses before one blanking give `pos`=1, not 2. Up and right pressed in the same debounced cycle from `pos`=5 give `pos`=1.
- **Selection handshake**: at `pos`=6, press select with `sel_ready`=0 for 20 cycles. Expect `sel_valid`=1, `sel_pos`=6, and `enable`=0. Moves and a blanking during this time leave `pos`=6. Raise `sel_ready` for 1 cycle and expect `sel_valid`=0 in the next cycle. Release `btn_sel` and expect `enable`=1 about 7 cycles later.
- **Held select**: hold `btn_sel` through the handshake. Expect the FSM to stay in RELEASE with no second offer until `btn_sel` is released and pressed again.
- **Reset mid-offer**: assert `rst` while `sel_valid`=1. Expect `sel_valid`=0, `enable`=1, `pos`=0, `sel_pos`=0 on the next cycle, with no pending move surviving.
